// File: rtl/gatherer_pkg.sv
// Shared types and constants for the four-tile packet gatherer.
// Holds the arbiter state encoding and the round-robin pick helper.
package gatherer_pkg;

    localparam int N_PORTS = 4;
    localparam int TID_W   = 2;
    localparam int CNT_W   = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // First requester found scanning last+1, last+2, last+3, last (mod 4).
    function automatic logic [TID_W-1:0] rr_pick(
        input logic [N_PORTS-1:0] req,
        input logic [TID_W-1:0]   last
    );
        logic [TID_W-1:0] idx;
        logic [TID_W-1:0] pick;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = last + TID_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gatherer_skid_buf.sv
// Two-entry output buffer: registered in_ready (no path from out_ready),
// full throughput while drained, payload held stable during stalls.
module gatherer_skid_buf #(
    parameter int W = 39
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         push;
    logic         pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    // Idle output reads as zero so reset and empty states present clean buses.
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/packet_gatherer.sv
// Merges four tile AXI-Stream inputs into one output, one whole packet at a
// time, with round-robin arbitration and a completed-packet counter.
module packet_gatherer
    import gatherer_pkg::*;
#(
    parameter int BW  = 32,
    parameter int BWB = BW / 8,
    parameter int N   = 4
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_low,
    input  logic [N-1:0]     stream_in_packet_TVALID,
    input  logic [BW*N-1:0]  stream_in_packet_TDATA,
    input  logic [BWB*N-1:0] stream_in_packet_TKEEP,
    input  logic [N-1:0]     stream_in_packet_TLAST,
    output logic [N-1:0]     stream_in_packet_TREADY,
    output logic             stream_out_packet_TVALID,
    output logic [BW-1:0]    stream_out_packet_TDATA,
    output logic [BWB-1:0]   stream_out_packet_TKEEP,
    output logic             stream_out_packet_TLAST,
    output logic [TID_W-1:0] stream_out_packet_TID,
    input  logic             stream_out_packet_TREADY,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int PW = BW + BWB + 1 + TID_W;

    logic [BW-1:0]    tdata_arr [N];
    logic [BWB-1:0]   tkeep_arr [N];

    state_e           state_q, state_d;
    logic [TID_W-1:0] g_q, g_d;
    logic [TID_W-1:0] lg_q, lg_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    logic             skid_in_valid;
    logic             skid_in_ready;
    logic [PW-1:0]    skid_in_data;
    logic [PW-1:0]    skid_out_data;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign tdata_arr[gi] = stream_in_packet_TDATA[BW*gi +: BW];
            assign tkeep_arr[gi] = stream_in_packet_TKEEP[BWB*gi +: BWB];
        end
    endgenerate

    always_comb begin
        state_d                 = state_q;
        g_d                     = g_q;
        lg_d                    = lg_q;
        stream_in_packet_TREADY = '0;
        skid_in_valid           = 1'b0;
        case (state_q)
            IDLE: begin
                if (|stream_in_packet_TVALID) begin
                    g_d     = rr_pick(stream_in_packet_TVALID, lg_q);
                    lg_d    = g_d;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Grant stays on g until its TLAST beat is accepted.
                stream_in_packet_TREADY[g_q] = skid_in_ready;
                skid_in_valid = stream_in_packet_TVALID[g_q];
                if (skid_in_valid && skid_in_ready && stream_in_packet_TLAST[g_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign skid_in_data = {g_q, stream_in_packet_TLAST[g_q], tkeep_arr[g_q], tdata_arr[g_q]};

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state_q     <= IDLE;
            g_q         <= '0;
            lg_q        <= TID_W'(N_PORTS - 1);
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            lg_q        <= lg_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    gatherer_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk_i       (clk_line),
        .rst_ni      (clk_line_rst_low),
        .in_valid_i  (skid_in_valid),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (skid_in_data),
        .out_valid_o (stream_out_packet_TVALID),
        .out_ready_i (stream_out_packet_TREADY),
        .out_data_o  (skid_out_data)
    );

    assign {stream_out_packet_TID, stream_out_packet_TLAST,
            stream_out_packet_TKEEP, stream_out_packet_TDATA} = skid_out_data;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (stream_out_packet_TVALID && stream_out_packet_TREADY && stream_out_packet_TLAST)
            pkt_count_d = pkt_count_q + 1'b1;
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_gatherer.sv
// Directed bench for packet_gatherer: per-tile drivers, output monitor with
// stall-stability checks, hand-computed expected beat sequences.
module tb_packet_gatherer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  tid;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  tv = '0;
    logic [31:0] td [4];
    logic [3:0]  tk [4];
    logic [3:0]  tl = '0;
    logic [3:0]  in_tready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [1:0]  out_tid;
    logic        out_rdy = 1'b1;
    logic [15:0] pkt_count;
    logic [127:0] in_data;
    logic [15:0]  in_keep;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    beat_t mon_q [$];

    assign in_data = {td[3], td[2], td[1], td[0]};
    assign in_keep = {tk[3], tk[2], tk[1], tk[0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    packet_gatherer dut (
        .clk_line                 (clk),
        .clk_line_rst_low         (rst_n),
        .stream_in_packet_TVALID  (tv),
        .stream_in_packet_TDATA   (in_data),
        .stream_in_packet_TKEEP   (in_keep),
        .stream_in_packet_TLAST   (tl),
        .stream_in_packet_TREADY  (in_tready),
        .stream_out_packet_TVALID (out_valid),
        .stream_out_packet_TDATA  (out_data),
        .stream_out_packet_TKEEP  (out_keep),
        .stream_out_packet_TLAST  (out_last),
        .stream_out_packet_TID    (out_tid),
        .stream_out_packet_TREADY (out_rdy),
        .pkt_count                (pkt_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Output monitor: records handshakes and checks payload stability across stalls.
    initial begin
        logic  prev_stall;
        beat_t held;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, held.data);
                    check("hold_last", out_last, held.last);
                    check("hold_tid", out_tid, held.tid);
                end
                if (out_valid && out_rdy)
                    mon_q.push_back('{out_data, out_keep, out_last, out_tid, cyc});
                prev_stall = out_valid && !out_rdy;
                held = '{out_data, out_keep, out_last, out_tid, cyc};
            end
        end
    end

    task automatic send_beat(input int tile, input logic [31:0] d, input logic last);
        logic hs;
        hs = 1'b0;
        tv[tile] = 1'b1;
        td[tile] = d;
        tk[tile] = 4'hF;
        tl[tile] = last;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = in_tready[tile];
            @(posedge clk);
            #1;
        end
        if (!hs) check($sformatf("accept_timeout_t%0d", tile), 0, 1);
        tv[tile] = 1'b0;
        tl[tile] = 1'b0;
    endtask

    task automatic send_pkt(input int tile, input int nb, input logic [31:0] d0, input logic [31:0] step);
        for (int b = 0; b < nb; b++)
            send_beat(tile, d0 + step * 32'(b), b == nb - 1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && mon_q.size() < n; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("beat_count", mon_q.size(), n);
    endtask

    task automatic check_beat(input int idx, input logic [31:0] d, input logic last, input logic [1:0] tid);
        if (idx < mon_q.size()) begin
            check($sformatf("beat%0d_data", idx), mon_q[idx].data, d);
            check($sformatf("beat%0d_last", idx), mon_q[idx].last, last);
            check($sformatf("beat%0d_tid", idx), mon_q[idx].tid, tid);
        end else begin
            check($sformatf("beat%0d_present", idx), 0, 1);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tv      = '0;
        tl      = '0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tready"}, in_tready, 0);
        check({pfx, "_tvalid"}, out_valid, 0);
        check({pfx, "_tdata"}, out_data, 0);
        check({pfx, "_tkeep"}, out_keep, 0);
        check({pfx, "_tlast"}, out_last, 0);
        check({pfx, "_tid"}, out_tid, 0);
        check({pfx, "_count"}, pkt_count, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        logic pat [6];
        for (int i = 0; i < 4; i++) begin
            td[i] = '0;
            tk[i] = '0;
        end

        // Reset state
        #3 rst_n = 1'b0;
        #10;
        check_reset_outputs("rst");
        do_reset();

        // Tile 0 three-beat packet, latency and content
        t0 = cyc;
        send_pkt(0, 3, 32'h11, 32'h11);
        wait_beats(3);
        check_beat(0, 32'h11, 0, 0);
        check_beat(1, 32'h22, 0, 0);
        check_beat(2, 32'h33, 1, 0);
        if (mon_q.size() > 0) begin
            check("first_latency", mon_q[0].cyc - t0, 2);
            check("keep", mon_q[0].keep, 4'hF);
        end
        check("count_one", pkt_count, 1);

        // All four tiles request together from reset
        do_reset();
        fork
            send_pkt(0, 2, 32'hA000_0000, 1);
            send_pkt(1, 2, 32'hA000_0100, 1);
            send_pkt(2, 2, 32'hA000_0200, 1);
            send_pkt(3, 2, 32'hA000_0300, 1);
        join
        wait_beats(8);
        for (int i = 0; i < 8; i++)
            check_beat(i, 32'hA000_0000 + 32'h100 * 32'(i / 2) + 32'(i % 2), (i % 2) == 1, 2'(i / 2));
        check("count_four", pkt_count, 4);

        // Tile 2 four-beat packet under downstream back-pressure
        do_reset();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        fork
            send_pkt(2, 4, 32'hC0, 1);
            begin
                logic dropped;
                dropped = 1'b0;
                for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
                for (int k = 1; k < 6; k++) begin
                    @(posedge clk);
                    #1;
                    out_rdy = pat[k];
                    @(negedge clk);
                    if ((k == 1 || k == 2) && !in_tready[2]) dropped = 1'b1;
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
                check("t2_ready_drop", dropped, 1);
            end
        join
        wait_beats(4);
        for (int i = 0; i < 4; i++)
            check_beat(i, 32'hC0 + 32'(i), i == 3, 2);
        check("count_stall", pkt_count, 1);

        // Tile 1 streaming single-beat packets while tile 3 requests
        do_reset();
        fork
            for (int i = 0; i < 3; i++) send_pkt(1, 1, 32'h100 + 32'(i), 0);
            for (int i = 0; i < 2; i++) send_pkt(3, 1, 32'h300 + 32'(i), 0);
        join
        wait_beats(5);
        check_beat(0, 32'h100, 1, 1);
        check_beat(1, 32'h300, 1, 3);
        check_beat(2, 32'h101, 1, 1);
        check_beat(3, 32'h301, 1, 3);
        check_beat(4, 32'h102, 1, 1);
        check("count_alt", pkt_count, 5);

        // Counter wrap, preloaded just below the top
        do_reset();
        force dut.pkt_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.pkt_count_q;
        send_pkt(0, 1, 32'h55, 0);
        wait_beats(1);
        check("count_ffff", pkt_count, 16'hFFFF);
        send_pkt(0, 1, 32'h56, 0);
        wait_beats(2);
        check("count_wrap", pkt_count, 16'h0000);

        // Reset in the middle of a packet
        do_reset();
        send_beat(0, 32'hD0, 0);
        send_beat(0, 32'hD1, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        mon_q.delete();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale", mon_q.size(), 0);
        send_pkt(3, 2, 32'hE0, 1);
        wait_beats(2);
        check_beat(0, 32'hE0, 0, 3);
        check_beat(1, 32'hE1, 1, 3);
        check("count_after_rst", pkt_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
